// File: rtl/poc_pkg.sv
// Shared types and constants for the POC scheduler and its helpers.
package poc_pkg;

    // Scheduler states; any other encoding falls back to IDLE.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RDY  = 3'd1,
        WR_BUF    = 3'd2,
        WR_STAT   = 3'd3,
        WAIT_DONE = 3'd4
    } state_e;

    // POC register-port address and direction encodings.
    localparam logic ADDR_STATUS = 1'b0;
    localparam logic ADDR_BUF    = 1'b1;
    localparam logic RW_READ     = 1'b0;
    localparam logic RW_WRITE    = 1'b1;

    // Status register bit positions.
    localparam int unsigned STAT_RDY_BIT  = 7;
    localparam int unsigned STAT_MODE_BIT = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last grant and wraps.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    // Walk the requesters in priority order and take the first one pending.
    always_comb begin
        int unsigned k;
        k       = 0;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            k = {{(32-IDX_W){1'b0}}, i_last_grant} + off;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!o_valid && i_req[k[IDX_W-1:0]]) begin
                o_valid               = 1'b1;
                o_gnt[k[IDX_W-1:0]]   = 1'b1;
                o_idx                 = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/poc_scheduler.sv
// Shares one POC between NUM_REQ byte producers: pick round-robin, wait for ready,
// write buffer then status to launch, then wait for completion or timeout.
module poc_scheduler
    import poc_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mode,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic                 o_addr,
    output logic                 o_rw,
    output logic [7:0]           o_wdata,
    input  logic [7:0]           i_status,
    input  logic                 i_irq,
    output logic                 o_busy,
    output logic [IDX_W-1:0]     o_owner,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]   owner_oh_q, owner_oh_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 mode_q, mode_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 seen_low_q, seen_low_d;
    logic                 done_d, err_d;

    logic [NUM_REQ-1:0]   gnt_d;
    logic                 addr_d, rw_d, busy_d;
    logic [7:0]           wdata_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic                 owner_req;
    logic [7:0]           owner_data;
    logic                 ready;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .i_req       (i_req),
        .i_last_grant(last_q),
        .o_gnt       (arb_gnt),
        .o_idx       (arb_idx),
        .o_valid     (arb_valid)
    );

    // Owner's request line and byte, selected through the latched one-hot owner.
    always_comb begin
        owner_req  = |(i_req & owner_oh_q);
        owner_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (owner_oh_q[k]) begin
                owner_data = owner_data | i_req_data[8*k +: 8];
            end
        end
    end

    assign ready = mode_q ? ~i_irq : i_status[STAT_RDY_BIT];

    // State register and transfer bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            owner_oh_q <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
            mode_q     <= 1'b0;
            timer_q    <= '0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            last_q     <= last_d;
            mode_q     <= mode_d;
            timer_q    <= timer_d;
            seen_low_q <= seen_low_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        last_d     = last_q;
        mode_d     = mode_q;
        timer_d    = timer_q;
        seen_low_d = seen_low_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    owner_d    = arb_idx;
                    owner_oh_d = arb_gnt;
                    mode_d     = i_mode;
                    state_d    = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                // A withdrawn request is dropped before anything is written.
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (ready) begin
                    last_d  = owner_q;
                    state_d = WR_BUF;
                end
            end
            WR_BUF: begin
                state_d = WR_STAT;
            end
            WR_STAT: begin
                timer_d    = '0;
                seen_low_d = 1'b0;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: begin
                seen_low_d = seen_low_q | ~i_status[STAT_RDY_BIT];
                timer_d    = timer_q + 1'b1;
                // Completion is checked first so it wins over a coincident timeout.
                if (seen_low_q && i_status[STAT_RDY_BIT]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        gnt_d   = '0;
        addr_d  = ADDR_STATUS;
        rw_d    = RW_READ;
        wdata_d = '0;
        busy_d  = (state_d != IDLE);
        case (state_d)
            WR_BUF: begin
                gnt_d   = owner_oh_q;
                addr_d  = ADDR_BUF;
                rw_d    = RW_WRITE;
                wdata_d = owner_data;
            end
            WR_STAT: begin
                // Bit 7 left clear: this write launches the print.
                rw_d                   = RW_WRITE;
                wdata_d[STAT_MODE_BIT] = mode_q;
            end
            default: begin
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_gnt   <= '0;
            o_addr  <= ADDR_STATUS;
            o_rw    <= RW_READ;
            o_wdata <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_gnt   <= gnt_d;
            o_addr  <= addr_d;
            o_rw    <= rw_d;
            o_wdata <= wdata_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
            o_err   <= err_d;
        end
    end

    assign o_owner = owner_q;

endmodule

// File: tb/tb_poc_scheduler.sv
// Directed bench for poc_scheduler with a small behavioural POC model.
module tb_poc_scheduler;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        addr, rw;
    logic [7:0]  wdata;
    logic [7:0]  status;
    logic        irq;
    logic        busy;
    logic [1:0]  owner;
    logic        done, err;

    always #5 clk = ~clk;

    poc_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_mode    (mode),
        .i_req     (req),
        .i_req_data(req_data),
        .o_gnt     (gnt),
        .o_addr    (addr),
        .o_rw      (rw),
        .o_wdata   (wdata),
        .i_status  (status),
        .i_irq     (irq),
        .o_busy    (busy),
        .o_owner   (owner),
        .o_done    (done),
        .o_err     (err)
    );

    // POC model: a status write latches the byte; a cleared bit 7 comes back after a delay.
    logic [7:0]  stat_q = 8'h80;
    int unsigned cnt_q  = 0;
    bit          complete_en;
    bit          hold_low;

    always @(posedge clk) begin
        if (rw === 1'b1 && addr === 1'b0) begin
            stat_q <= wdata;
            cnt_q  <= 2;
        end else if (!stat_q[7] && complete_en) begin
            if (cnt_q == 0) stat_q[7] <= 1'b1;
            else            cnt_q <= cnt_q - 1;
        end
    end

    assign status = hold_low ? (stat_q & 8'h7F) : stat_q;

    // Monitor, sampled on the falling edge.
    int unsigned cyc = 0, n_rw = 0, n_done = 0, n_err = 0, err_cyc = 0;
    logic        wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int unsigned wr_cyc_q[$];
    logic [3:0]  gnt_vec_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rw === 1'b1) begin
            n_rw <= n_rw + 1;
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wdata);
            wr_cyc_q.push_back(cyc);
        end
        if ((|gnt) === 1'b1) gnt_vec_q.push_back(gnt);
        if (done === 1'b1) n_done <= n_done + 1;
        if (err === 1'b1) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
    end

    int unsigned n_chk = 0, n_pass = 0;

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int unsigned base, input int unsigned maxc,
                            output int unsigned lat);
        lat = 0;
        while (gnt_vec_q.size() == base && lat < maxc) begin
            tick;
            lat++;
        end
    endtask

    task automatic wait_idle(input string name, input int unsigned maxc);
        int unsigned k;
        k = 0;
        while (busy !== 1'b0 && k < maxc) begin
            tick;
            k++;
        end
        check(name, busy, 0);
    endtask

    typedef struct {
        bit          mode;
        logic [3:0]  req;
        logic [31:0] data;
        int unsigned exp_idx;
        logic [7:0]  exp_buf;
        logic [7:0]  exp_stat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int unsigned lat, bg, bw, bd, be, bad, k;

        // Round-robin history is carried across rows: last grant starts at 3.
        vecs[0] = '{1'b0, 4'b0001, 32'h000000A5, 0, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 4'b0110, 32'h11225A33, 1, 8'h5A, 8'h00};
        vecs[2] = '{1'b1, 4'b1001, 32'hC3445566, 3, 8'hC3, 8'h01};
        vecs[3] = '{1'b0, 4'b1111, 32'h0102037E, 0, 8'h7E, 8'h00};
        vecs[4] = '{1'b1, 4'b1100, 32'h0FE10D0C, 2, 8'hE1, 8'h01};
        vecs[5] = '{1'b0, 4'b0011, 32'h998877F0, 0, 8'hF0, 8'h00};

        rst = 1'b1; req = '0; mode = 1'b0; irq = 1'b1; req_data = '0;
        complete_en = 1'b1; hold_low = 1'b0;
        do_reset;
        check("reset_outputs", {gnt, addr, rw, wdata, busy, owner, done, err}, 0);

        // Table: one full transfer per row.
        for (int i = 0; i < 6; i++) begin
            mode     = vecs[i].mode;
            irq      = ~vecs[i].mode;
            hold_low = vecs[i].mode;
            bg = gnt_vec_q.size(); bw = wr_data_q.size(); bd = n_done;
            req_data = vecs[i].data;
            req      = vecs[i].req;
            wait_gnt(bg, 50, lat);
            check($sformatf("v%0d_latency", i), lat, 2);
            check($sformatf("v%0d_gnt", i), gnt, 4'b0001 << vecs[i].exp_idx);
            check($sformatf("v%0d_owner", i), owner, vecs[i].exp_idx);
            req = '0;
            hold_low = 1'b0;
            wait_idle($sformatf("v%0d_idle", i), 60);
            check($sformatf("v%0d_done_cnt", i), n_done - bd, 1);
            check($sformatf("v%0d_gnt_cnt", i), gnt_vec_q.size() - bg, 1);
            check($sformatf("v%0d_wr_cnt", i), wr_data_q.size() - bw, 2);
            if (wr_data_q.size() >= bw + 2) begin
                check($sformatf("v%0d_wr_addrs", i), {wr_addr_q[bw], wr_addr_q[bw+1]}, 2'b10);
                check($sformatf("v%0d_buf", i), wr_data_q[bw], vecs[i].exp_buf);
                check($sformatf("v%0d_stat", i), wr_data_q[bw+1], vecs[i].exp_stat);
                check($sformatf("v%0d_consec", i), wr_cyc_q[bw+1] - wr_cyc_q[bw], 1);
            end
        end
        irq = 1'b1;

        // Interrupt mode: no writes while irq stays high, owner held throughout.
        do_reset;
        mode = 1'b1; irq = 1'b1;
        bw = wr_data_q.size(); bg = gnt_vec_q.size(); bad = 0;
        req_data = 32'h003C0000;
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (busy !== 1'b1 || owner !== 2'd2) bad++;
        end
        check("irq_hold_writes", wr_data_q.size() - bw, 0);
        check("irq_hold_owner", bad, 0);
        irq = 1'b0;
        wait_gnt(bg, 20, lat);
        check("irq_gnt", gnt, 4'b0100);
        req = '0;
        k = 0; bad = 0;
        while (busy !== 1'b0 && k < 60) begin
            if (owner !== 2'd2) bad++;
            tick;
            k++;
        end
        check("irq_idle", busy, 0);
        check("irq_owner_xfer", bad, 0);
        if (wr_data_q.size() >= bw + 2) begin
            check("irq_buf", wr_data_q[bw], 8'h3C);
            check("irq_stat", wr_data_q[bw+1], 8'h01);
        end else begin
            check("irq_wr_cnt", wr_data_q.size() - bw, 2);
        end
        irq = 1'b1;

        // All requesters held: strict rotation, one completion per grant.
        do_reset;
        mode = 1'b0;
        bg = gnt_vec_q.size(); bd = n_done; k = 0;
        req_data = 32'h44332211;
        req = 4'b1111;
        while (gnt_vec_q.size() - bg < 5 && k < 400) begin
            tick;
            k++;
        end
        req = '0;
        wait_idle("rr_idle", 60);
        check("rr_gnt_cnt", gnt_vec_q.size() - bg, 5);
        if (gnt_vec_q.size() >= bg + 5) begin
            check("rr_order", {gnt_vec_q[bg], gnt_vec_q[bg+1], gnt_vec_q[bg+2],
                               gnt_vec_q[bg+3], gnt_vec_q[bg+4]}, 20'h12481);
        end
        check("rr_done_cnt", n_done - bd, 5);

        // Request withdrawn while waiting for ready.
        do_reset;
        hold_low = 1'b1; mode = 1'b0;
        bg = gnt_vec_q.size(); bw = n_rw;
        req = 4'b0100;
        tick; tick; tick;
        check("drop_busy", busy, 1);
        req = '0;
        tick; tick;
        check("drop_idle", busy, 0);
        check("drop_no_gnt", gnt_vec_q.size() - bg, 0);
        check("drop_no_write", n_rw - bw, 0);
        hold_low = 1'b0;

        // POC never finishes: abort after the timeout, then the next requester is served.
        do_reset;
        complete_en = 1'b0; mode = 1'b0;
        bg = gnt_vec_q.size(); bw = wr_data_q.size(); bd = n_done; be = n_err;
        req_data = 32'h77000000;
        req = 4'b0010;
        wait_gnt(bg, 20, lat);
        check("to_gnt", gnt, 4'b0010);
        req = 4'b1010;
        bg = gnt_vec_q.size();
        k = 0;
        while (n_err == be && k < 100) begin
            tick;
            k++;
        end
        check("to_err_seen", n_err - be, 1);
        if (wr_cyc_q.size() >= bw + 2) begin
            check("to_err_delay", err_cyc - wr_cyc_q[bw+1], TIMEOUT_CYC + 1);
        end
        mode = 1'b1; irq = 1'b0;
        wait_gnt(bg, 20, lat);
        check("to_next_gnt", gnt, 4'b1000);
        req = '0;
        complete_en = 1'b1;
        wait_idle("to_idle", 60);
        check("to_err_once", n_err - be, 1);
        check("to_done_cnt", n_done - bd, 1);
        irq = 1'b1;

        // Reset during WAIT_DONE aborts immediately; requester 0 first afterwards.
        do_reset;
        complete_en = 1'b0; mode = 1'b0;
        bg = gnt_vec_q.size();
        req = 4'b0100;
        wait_gnt(bg, 20, lat);
        req = '0;
        tick; tick; tick; tick;
        check("rst_busy_before", busy, 1);
        bw = wr_data_q.size();
        rst = 1'b1;
        tick;
        check("rst_outputs", {gnt, addr, rw, wdata, busy, owner, done, err}, 0);
        rst = 1'b0;
        complete_en = 1'b1;
        tick; tick; tick; tick; tick;
        check("rst_no_write", wr_data_q.size() - bw, 0);
        bg = gnt_vec_q.size();
        req = 4'b1111;
        wait_gnt(bg, 20, lat);
        check("rst_first_gnt", gnt, 4'b0001);
        req = '0;
        wait_idle("rst_idle", 60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/poc_scheduler.md
Name: poc_scheduler

Overview:
- Shares one POC (8-bit parallel output controller) between NUM_REQ byte-producing requesters.
- Sits between requesters and the POC processor-side register port; drives addr/rw/data exactly as a CPU would.
- Selects a requester round-robin, waits for POC ready (query or interrupt method), writes buffer then status to launch the print, and waits for completion or timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 1024, max cycles in WAIT_DONE before abort.
- IDX_W, $clog2(NUM_REQ), owner index width (derived, not overridden).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_mode  in  1  0 = query (poll status[7]), 1 = interrupt (use i_irq).
- i_req  in  NUM_REQ  per-requester byte pending; held until granted.
- i_req_data  in  8*NUM_REQ  byte of requester k at [8k+7:8k]; stable while i_req[k]=1.
- o_gnt  out  NUM_REQ  one-hot one-cycle pulse: byte taken.
- o_addr  out  1  to POC i_addr: 0 = status, 1 = buffer.
- o_rw  out  1  to POC i_rw: 0 = read, 1 = write.
- o_wdata  out  8  to POC i_din.
- i_status  in  8  from POC o_dout.
- i_irq  in  1  from POC o_irq, active-low.
- o_busy  out  1  state != IDLE.
- o_owner  out  IDX_W  index of current requester; valid when o_busy=1.
- o_done  out  1  one-cycle pulse: transfer completed.
- o_err  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset (i_rst=1 at clock edge): state IDLE; outputs o_gnt=0, o_addr=0, o_rw=0, o_wdata=0, o_busy=0, o_owner=0, o_done=0, o_err=0. Internal: last_grant=NUM_REQ-1, so requester 0 has first priority. Reset mid-transfer aborts at once with no further POC writes.
- Outputs are registered. All state changes occur on the rising edge of i_clk.
- Round-robin: search starts at last_grant+1 and wraps modulo NUM_REQ. last_grant updates on o_gnt and on timeout abort.
- IDLE:
  - o_rw=0, o_addr=0.
  - If any i_req is set: latch owner and mode_q=i_mode, go to WAIT_RDY.
  - mode_q stays constant until the next return to IDLE.
- WAIT_RDY:
  - Read status (o_rw=0, o_addr=0).
  - Ready condition: query mode needs i_status[7]=1; interrupt mode needs i_irq=0.
  - When ready, go to WR_BUF.
  - If i_req[owner] drops, return to IDLE with no writes and no grant.
  - No timeout in this state.
- WR_BUF:
  - One cycle: o_rw=1, o_addr=1, o_wdata=i_req_data[owner].
  - o_gnt[owner]=1 in the same cycle.
  - Go to WR_STAT.
- WR_STAT:
  - One cycle: o_rw=1, o_addr=0, o_wdata={7'b0,mode_q}. Clearing bit7 launches the print.
  - Clear timer and seen_low; go to WAIT_DONE.
- WAIT_DONE:
  - Read status.
  - Set seen_low when i_status[7]=0.
  - Done when seen_low=1 and i_status[7]=1: pulse o_done, go to IDLE.
  - Timer reaching TIMEOUT_CYC-1: pulse o_err, go to IDLE.
  - If done and timeout occur in the same cycle, done wins.
- Latency, request to grant: minimum 2 cycles (req seen in IDLE, WAIT_RDY ready, o_gnt in WR_BUF). Buffer and status writes are in consecutive cycles.
- Simultaneous events:
  - A new request arriving during a transfer waits.
  - The granted requester may reassert i_req the cycle after o_gnt; it then has lowest priority.
- Only one POC write per cycle; o_rw=1 only in WR_BUF or WR_STAT.
- Illegal state encoding goes to IDLE.

Decomposition:
- poc_pkg holds:
  - state enum: IDLE, WAIT_RDY, WR_BUF, WR_STAT, WAIT_DONE.
  - ADDR_STATUS=1'b0, ADDR_BUF=1'b1.
  - RW_READ=0, RW_WRITE=1.
  - STAT_RDY_BIT=7, STAT_MODE_BIT=0.
- Sub-module rr_arbiter (NUM_REQ): combinational one-hot pick from req vector and last_grant, plus encoded index. Reused by future shared-resource blocks.

Test Plan:
- Query mode, i_req=4'b0001, data0=8'hA5, i_status=8'h80: o_gnt=0001 two cycles after req. Writes are buf=8'hA5 then status=8'h00. Model drops status[7] then restores it; o_done pulses once.
- Interrupt mode, i_irq held 1 for 10 cycles, then 0: no writes while i_irq=1. Status write carries 8'h01, and o_owner stays correct throughout.
- i_req=4'b1111 held, POC model always completes: grant order is 0,1,2,3,0 with exactly one o_done per grant.
- Requester 2 drops i_req while in WAIT_RDY: return to IDLE, o_gnt stays 0 and no o_rw=1 cycles occur.
- POC model never restores status[7] after launch: o_err pulses TIMEOUT_CYC cycles after WR_STAT, and the next requester is served.
- Assert i_rst during WAIT_DONE: next cycle all outputs are 0 and state is IDLE. Requester 0 is then served first.
